// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the
// round-robin fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  localparam int DefNumReq    = 4;
  localparam int DefDataWidth = 32;
  localparam int DefMaxBurst  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/fifo side bundle of the write-port
// arbiter; master drives producers and fifo flag.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int DataWidth = DefDataWidth
);

  localparam int IdW = $clog2(NumReq);

  logic [NumReq-1:0]                reqValid;
  logic [NumReq-1:0][DataWidth-1:0] reqData;
  logic [NumReq-1:0]                reqReady;
  logic                             fifoFull;
  logic                             fifoWriteEn;
  logic [DataWidth-1:0]             fifoWriteData;
  logic                             grantValid;
  logic [IdW-1:0]                   grantId;

  modport master (
    output reqValid,
    output reqData,
    output fifoFull,
    input  reqReady,
    input  fifoWriteEn,
    input  fifoWriteData,
    input  grantValid,
    input  grantId
  );

  modport slave (
    input  reqValid,
    input  reqData,
    input  fifoFull,
    output reqReady,
    output fifoWriteEn,
    output fifoWriteData,
    output grantValid,
    output grantId
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from
// lastGrant+1 upward, lastGrant itself last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NumReq = DefNumReq
) (
  input  logic [NumReq-1:0]         reqValid,
  input  logic [$clog2(NumReq)-1:0] lastGrant,
  output logic                      anyValid,
  output logic [$clog2(NumReq)-1:0] pickId
);

  localparam int IdW = $clog2(NumReq);

  logic [IdW-1:0] idx;

  // NumReq is a power of 2, so the wrap is
  // just truncation of the sum.
  always_comb begin
    anyValid = 1'b0;
    pickId   = '0;
    idx      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = lastGrant + IdW'(i);
      if (!anyValid && reqValid[idx]) begin
        anyValid = 1'b1;
        pickId   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter sharing one
// fifo write port among NumReq producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int DataWidth = DefDataWidth,
  parameter int MaxBurst  = DefMaxBurst
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst);
  localparam logic [CntW-1:0] LastBeat =
    CntW'(MaxBurst - 1);

  arb_state_e      state, stateN;
  logic [IdW-1:0]  owner, ownerN;
  logic [IdW-1:0]  lastGrant, lastGrantN;
  logic [IdW-1:0]  pickId;
  logic [CntW-1:0] beatCnt, beatCntN;
  logic            anyValid;
  logic            ownValid;
  logic            xfer;

  rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .reqValid  (bus.reqValid),
    .lastGrant (lastGrant),
    .anyValid  (anyValid),
    .pickId    (pickId)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      lastGrant <= IdW'(NumReq - 1);
      beatCnt   <= '0;
    end else begin
      state     <= stateN;
      owner     <= ownerN;
      lastGrant <= lastGrantN;
      beatCnt   <= beatCntN;
    end
  end

  assign ownValid = bus.reqValid[owner];

  always_comb begin
    stateN          = state;
    ownerN          = owner;
    lastGrantN      = lastGrant;
    beatCntN        = beatCnt;
    xfer            = 1'b0;
    bus.reqReady    = '0;
    bus.fifoWriteEn = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (anyValid) begin
          stateN   = ARB_BURST;
          ownerN   = pickId;
          beatCntN = '0;
        end
      end
      ARB_BURST: begin
        bus.reqReady[owner] = !bus.fifoFull;
        xfer = ownValid && !bus.fifoFull;
        bus.fifoWriteEn = xfer;
        // A stall (full with owner valid) holds
        // both state and beat count.
        if (!ownValid ||
            (xfer && beatCnt == LastBeat)) begin
          stateN     = ARB_IDLE;
          lastGrantN = owner;
        end else if (xfer) begin
          beatCntN = beatCnt + 1'b1;
        end
      end
      default: stateN = ARB_IDLE;
    endcase
  end

  assign bus.grantValid = (state == ARB_BURST);
  assign bus.grantId    = owner;
  assign bus.fifoWriteData =
    bus.grantValid ? bus.reqData[owner]
                   : {DataWidth{1'b0}};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and fifo-model checks for the
// round-robin fifo write arbiter.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(
    .NumReq    (N),
    .DataWidth (DW)
  ) bus ();

  fifo_wr_arbiter #(
    .NumReq    (N),
    .DataWidth (DW),
    .MaxBurst  (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(
    input string tag,
    input int    id
  );
    check({tag, "_gv"}, 64'(bus.grantValid), 1);
    check({tag, "_gid"}, 64'(bus.grantId), id);
    check({tag, "_we"}, 64'(bus.fifoWriteEn), 1);
    check({tag, "_rdy"}, 64'(bus.reqReady),
          64'(1) << id);
    check({tag, "_dat"}, 64'(bus.fifoWriteData),
          64'h0000_0000_D000_0000 | 64'(id));
  endtask

  task automatic zeros(input string tag);
    check({tag, "_rdy"}, 64'(bus.reqReady), 0);
    check({tag, "_we"}, 64'(bus.fifoWriteEn), 0);
    check({tag, "_gv"}, 64'(bus.grantValid), 0);
    check({tag, "_gid"}, 64'(bus.grantId), 0);
    check({tag, "_dat"}, 64'(bus.fifoWriteData), 0);
  endtask

  int seq [N];
  int cnt;
  int writes;
  int hs;
  int nh;
  int hid;
  bit pop;

  initial begin
    rst          = 1'b1;
    bus.reqValid = '0;
    bus.fifoFull = 1'b0;
    for (int i = 0; i < N; i++)
      bus.reqData[i] = 32'hD000_0000 | 32'(i);
    tick;
    tick;

    // all four valid: 0,1,2,3,0 in bursts of 4
    bus.reqValid = 4'b1111;
    rst = 1'b0;
    #1;
    zeros("rst0");
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < MB; k++) begin
        tick; #1;
        beat("rr", b % N);
      end
      tick; #1;
      check("rr_idle", 64'(bus.grantValid), 0);
    end
    bus.reqValid = '0;

    // lone requester 2: bursts 4,4,2
    bus.reqValid = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < ((b < 2) ? 4 : 2); k++) begin
        tick; #1;
        beat("solo", 2);
      end
      if (b < 2) begin
        tick; #1;
        check("solo_idle", 64'(bus.grantValid), 0);
      end
    end
    tick;
    bus.reqValid = '0;
    #1;
    check("solo_drop_gv", 64'(bus.grantValid), 1);
    check("solo_drop_we", 64'(bus.fifoWriteEn), 0);
    tick; #1;
    check("solo_end", 64'(bus.grantValid), 0);

    // requester 1 stalled 3 cycles after 2 beats
    bus.reqValid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick; #1;
      beat("stall_pre", 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      bus.fifoFull = 1'b1;
      #1;
      check("stall_rdy", 64'(bus.reqReady), 0);
      check("stall_we", 64'(bus.fifoWriteEn), 0);
      check("stall_gv", 64'(bus.grantValid), 1);
    end
    tick;
    bus.fifoFull = 1'b0;
    #1;
    beat("stall_post", 1);
    tick; #1;
    beat("stall_post", 1);
    tick; #1;
    check("stall_idle", 64'(bus.grantValid), 0);
    bus.reqValid = '0;

    // requester 3 drops early; scan resumes at 0
    bus.reqValid = 4'b1000;
    tick; #1;
    beat("drop", 3);
    tick;
    bus.reqValid = 4'b0001;
    #1;
    check("drop_gv", 64'(bus.grantValid), 1);
    check("drop_gid", 64'(bus.grantId), 3);
    check("drop_we", 64'(bus.fifoWriteEn), 0);
    tick; #1;
    check("drop_idle", 64'(bus.grantValid), 0);
    bus.reqValid = 4'b0011;
    tick; #1;
    beat("drop_next", 0);
    tick;
    bus.reqValid = '0;
    tick; #1;
    check("drop_end", 64'(bus.grantValid), 0);

    // reset during beat 2 of a requester 1 burst
    bus.reqValid = 4'b0010;
    tick; #1;
    beat("mrst_b1", 1);
    tick;
    rst = 1'b1;
    #1;
    beat("mrst_b2", 1);
    tick;
    rst = 1'b0;
    #1;
    zeros("mrst");
    tick; #1;
    beat("mrst_regrant", 1);
    tick;
    bus.reqValid = '0;
    tick; #1;
    check("mrst_end", 64'(bus.grantValid), 0);

    // random traffic against a depth-8 fifo model
    for (int i = 0; i < N; i++) seq[i] = 0;
    cnt    = 0;
    writes = 0;
    hs     = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        bus.reqData[i] = {8'(i), 24'(seq[i])};
      bus.reqValid = 4'($urandom);
      bus.fifoFull = (cnt == 8);
      #1;
      nh  = 0;
      hid = 0;
      for (int i = 0; i < N; i++)
        if (bus.reqValid[i] && bus.reqReady[i]) begin
          nh++;
          hid = i;
        end
      check("rnd_hs", 64'(nh), 64'(bus.fifoWriteEn));
      if (bus.fifoWriteEn) begin
        check("rnd_nofull", 64'(bus.fifoFull), 0);
        check("rnd_data", 64'(bus.fifoWriteData),
              64'({8'(hid), 24'(seq[hid])}));
      end
      if (nh > 0) seq[hid]++;
      hs     += nh;
      writes += int'(bus.fifoWriteEn);
      pop = (cnt > 0) && ($urandom_range(0, 2) == 0);
      cnt = cnt + int'(bus.fifoWriteEn) - int'(pop);
      tick;
    end
    check("rnd_total", 64'(writes), 64'(hs));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
